fetch_exec_unit: RTL and testbench

- Datapath stage directly downstream of the IDLE/FETCH/EXEC control sequencer.
- Consumes the sequencer's 2-bit state `cs`.
- Fetches 8-bit instructions from an internal loadable instruction memory and executes a minimal accumulator ISA.
- Returns `halt` to the sequencer so a HALT instruction sends it back to IDLE.

---
 rtl/fetch_exec_unit.sv | 128 ++++++++++++
 tb/tb_fetch_exec_unit.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_exec_unit.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | fetch_exec_unit                                                           |
// | Fetch/execute datapath for an 8-bit accumulator ISA fed by a sequencer.   |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module fetch_exec_unit #(
    parameter int PC_W   = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        cs,
    input  logic              imem_we,
    input  logic [PC_W-1:0]   imem_addr,
    input  logic [7:0]        imem_wdata,
    input  logic              pc_clr,
    output logic              halt,
    output logic [PC_W-1:0]   pc,
    output logic [DATA_W-1:0] acc,
    output logic              carry,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid
);

    localparam logic [1:0] c_CS_IDLE  = 2'b00;
    localparam logic [1:0] c_CS_FETCH = 2'b01;
    localparam logic [1:0] c_CS_EXEC  = 2'b10;

    localparam logic [2:0] c_OP_LDI  = 3'b001;
    localparam logic [2:0] c_OP_ADDI = 3'b010;
    localparam logic [2:0] c_OP_SUBI = 3'b011;
    localparam logic [2:0] c_OP_JMP  = 3'b100;
    localparam logic [2:0] c_OP_JZ   = 3'b101;
    localparam logic [2:0] c_OP_OUT  = 3'b110;
    localparam logic [2:0] c_OP_HALT = 3'b111;

    logic [7:0]        r_imem [0:(2**PC_W)-1];
    logic [7:0]        r_ir;
    logic [PC_W-1:0]   r_pc;
    logic [DATA_W-1:0] r_acc;
    logic              r_carry;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_valid;

    logic [2:0]        w_op;
    logic [DATA_W-1:0] w_imm;
    logic [PC_W-1:0]   w_target;
    logic [DATA_W:0]   w_sum;
    logic [DATA_W-1:0] w_diff;
    logic              w_borrow;

    assign w_op     = r_ir[7:5];
    assign w_imm    = DATA_W'(r_ir[4:0]);
    assign w_target = r_ir[PC_W-1:0];
    assign w_sum    = {1'b0, r_acc} + {1'b0, w_imm};
    assign w_diff   = r_acc - w_imm;
    assign w_borrow = (r_acc < w_imm);

    assign halt      = (cs == c_CS_EXEC) && (w_op == c_OP_HALT);
    assign pc        = r_pc;
    assign acc       = r_acc;
    assign carry     = r_carry;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;

    // Program storage survives reset so a run can be repeated after a reset.
    always_ff @(posedge clk) begin
        if ((cs == c_CS_IDLE) && imem_we) begin
            r_imem[imem_addr] <= imem_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ir        <= '0;
            r_pc        <= '0;
            r_acc       <= '0;
            r_carry     <= 1'b0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (cs)
                c_CS_IDLE: begin
                    if (pc_clr) begin
                        r_pc <= '0;
                    end
                end
                c_CS_FETCH: begin
                    r_ir <= r_imem[r_pc];
                    r_pc <= r_pc + PC_W'(1);
                end
                c_CS_EXEC: begin
                    case (w_op)
                        c_OP_LDI: begin
                            r_acc   <= w_imm;
                            r_carry <= 1'b0;
                        end
                        c_OP_ADDI: begin
                            r_acc   <= w_sum[DATA_W-1:0];
                            r_carry <= w_sum[DATA_W];
                        end
                        c_OP_SUBI: begin
                            r_acc   <= w_diff;
                            r_carry <= w_borrow;
                        end
                        // Jumps overwrite the increment already applied in FETCH.
                        c_OP_JMP: r_pc <= w_target;
                        c_OP_JZ: begin
                            if (r_acc == '0) begin
                                r_pc <= w_target;
                            end
                        end
                        c_OP_OUT: begin
                            r_out_data  <= r_acc;
                            r_out_valid <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_exec_unit.sv
`default_nettype none
// Testbench for fetch_exec_unit: directed program runs plus randomized
// sequencer activity checked against an integer-arithmetic reference model.
module tb_fetch_exec_unit;

    localparam int PC_W   = 4;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int DMOD   = 256;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [1:0]        cs = 2'b00;
    logic              imem_we = 1'b0;
    logic [PC_W-1:0]   imem_addr = '0;
    logic [7:0]        imem_wdata = '0;
    logic              pc_clr = 1'b0;
    logic              halt;
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] acc;
    logic              carry;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;

    int n_tests = 0;
    int n_fail  = 0;

    int m_mem [DEPTH];
    int m_ir, m_pc, m_acc, m_carry, m_od, m_ov;

    fetch_exec_unit #(.PC_W(PC_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset), .cs(cs), .imem_we(imem_we),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .pc_clr(pc_clr),
        .halt(halt), .pc(pc), .acc(acc), .carry(carry),
        .out_data(out_data), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_ir = 0; m_pc = 0; m_acc = 0; m_carry = 0; m_od = 0; m_ov = 0;
    endtask

    // Architectural effect of one clock edge, from the ISA description.
    task automatic model_edge(input logic [1:0] c, input logic we, input int a,
                              input int d, input logic clr);
        int op, imm;
        m_ov = 0;
        case (c)
            2'b00: begin
                if (we)  m_mem[a] = d;
                if (clr) m_pc = 0;
            end
            2'b01: begin
                m_ir = m_mem[m_pc];
                m_pc = (m_pc + 1) % DEPTH;
            end
            2'b10: begin
                op  = m_ir / 32;
                imm = m_ir % 32;
                case (op)
                    1: begin m_acc = imm; m_carry = 0; end
                    2: begin m_carry = (m_acc + imm >= DMOD) ? 1 : 0; m_acc = (m_acc + imm) % DMOD; end
                    3: begin m_carry = (m_acc < imm) ? 1 : 0; m_acc = (m_acc - imm + DMOD) % DMOD; end
                    4: m_pc = imm % DEPTH;
                    5: if (m_acc == 0) m_pc = imm % DEPTH;
                    6: begin m_od = m_acc; m_ov = 1; end
                    default: ;
                endcase
            end
            default: ;
        endcase
    endtask

    task automatic cycle(input logic [1:0] c, input logic we, input int a,
                         input int d, input logic clr);
        cs = c; imem_we = we; imem_addr = PC_W'(a); imem_wdata = 8'(d); pc_clr = clr;
        @(posedge clk);
        model_edge(c, we, a, d, clr);
        #1;
        imem_we = 1'b0; pc_clr = 1'b0;
    endtask

    task automatic write_mem(input int a, input int d); cycle(2'b00, 1'b1, a, d, 1'b0); endtask
    task automatic clear_pc();  cycle(2'b00, 1'b0, 0, 0, 1'b1); endtask
    task automatic fetch();     cycle(2'b01, 1'b0, 0, 0, 1'b0); endtask
    task automatic exec();      cycle(2'b10, 1'b0, 0, 0, 1'b0); endtask

    task automatic test_reset();
        reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({pc, acc, carry, out_data, out_valid, halt} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: pc=%0h acc=%0h carry=%0b out_data=%0h out_valid=%0b halt=%0b, required all 0",
                     pc, acc, carry, out_data, out_valid, halt);
        end
        reset = 1'b1;
        for (int i = 0; i < DEPTH; i++) write_mem(i, 0);
        n_tests++;
        if (pc !== 4'd0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle_hold: pc=%0h out_valid=%0b, required 0/0", pc, out_valid);
        end
    endtask

    task automatic test_load_run();
        int prog [4] = '{8'h25, 8'h43, 8'hC0, 8'hE0};
        int exp_acc [4] = '{5, 8, 8, 8};
        int ov_count = 0;
        for (int i = 0; i < 4; i++) write_mem(i, prog[i]);
        clear_pc();
        for (int i = 0; i < 4; i++) begin
            cs = 2'b01; #1;
            n_tests++;
            if (halt !== 1'b0) begin
                n_fail++; $display("FAIL run_halt_fetch%0d: halt=%0b, required 0", i, halt);
            end
            fetch();
            if (out_valid) ov_count++;
            cs = 2'b10; #1;
            n_tests++;
            if (halt !== (i == 3)) begin
                n_fail++; $display("FAIL run_halt_exec%0d: halt=%0b, required %0b", i, halt, (i == 3));
            end
            exec();
            if (out_valid) ov_count++;
            n_tests++;
            if (acc !== 8'(exp_acc[i])) begin
                n_fail++; $display("FAIL run_acc%0d: acc=%0d, required %0d", i, acc, exp_acc[i]);
            end
            if (i == 2) begin
                n_tests++;
                if (out_valid !== 1'b1 || out_data !== 8'd8) begin
                    n_fail++; $display("FAIL run_out: out_valid=%0b out_data=%0d, required 1/8", out_valid, out_data);
                end
            end
        end
        n_tests++;
        if (ov_count != 1 || pc !== 4'd4) begin
            n_fail++; $display("FAIL run_end: out_valid pulses=%0d pc=%0d, required 1/4", ov_count, pc);
        end
    endtask

    task automatic test_carry();
        write_mem(0, 8'h3F);
        for (int i = 1; i <= 8; i++) write_mem(i, 8'h5F);
        write_mem(9, 8'h61);
        clear_pc();
        fetch(); exec();
        for (int k = 1; k <= 8; k++) begin
            fetch(); exec();
            n_tests++;
            if (acc !== 8'((31 * (k + 1)) % 256) || carry !== (k == 8)) begin
                n_fail++; $display("FAIL carry_addi%0d: acc=%0d carry=%0b, required %0d/%0b",
                                   k, acc, carry, (31 * (k + 1)) % 256, (k == 8));
            end
        end
        fetch(); exec();
        n_tests++;
        if (acc !== 8'd22 || carry !== 1'b0) begin
            n_fail++; $display("FAIL carry_subi: acc=%0d carry=%0b, required 22/0", acc, carry);
        end
        write_mem(0, 8'h20); write_mem(1, 8'h61); clear_pc();
        fetch(); exec(); fetch(); exec();
        n_tests++;
        if (acc !== 8'hFF || carry !== 1'b1) begin
            n_fail++; $display("FAIL borrow: acc=%0h carry=%0b, required ff/1", acc, carry);
        end
    endtask

    task automatic test_jumps();
        write_mem(0, 8'h20); write_mem(1, 8'hA5);
        for (int i = 2; i < 5; i++) write_mem(i, 8'hC0);
        write_mem(5, 8'hE0);
        clear_pc();
        fetch(); exec(); fetch(); exec();
        n_tests++;
        if (pc !== 4'd5) begin
            n_fail++; $display("FAIL jz_taken: pc=%0d, required 5", pc);
        end
        fetch(); cs = 2'b10; #1;
        n_tests++;
        if (halt !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL jz_target_halt: halt=%0b out_valid=%0b, required 1/0", halt, out_valid);
        end
        exec();
        write_mem(0, 8'h21); clear_pc();
        fetch(); exec(); fetch(); exec();
        n_tests++;
        if (pc !== 4'd2) begin
            n_fail++; $display("FAIL jz_not_taken: pc=%0d, required 2", pc);
        end
        write_mem(0, 8'h8F); write_mem(15, 8'h80); clear_pc();
        fetch(); exec();
        n_tests++;
        if (pc !== 4'd15) begin
            n_fail++; $display("FAIL jmp_15: pc=%0d, required 15", pc);
        end
        fetch();
        n_tests++;
        if (pc !== 4'd0) begin
            n_fail++; $display("FAIL pc_wrap: pc=%0d, required 0", pc);
        end
        exec();
        n_tests++;
        if (pc !== 4'd0) begin
            n_fail++; $display("FAIL jmp_0: pc=%0d, required 0", pc);
        end
    endtask

    task automatic test_write_gating();
        write_mem(7, 8'h2C); write_mem(0, 8'h00); write_mem(1, 8'h87); clear_pc();
        cycle(2'b01, 1'b1, 7, 8'h3A, 1'b1);
        cycle(2'b10, 1'b1, 7, 8'h3A, 1'b1);
        n_tests++;
        if (pc !== 4'd1) begin
            n_fail++; $display("FAIL gate_pc_clr: pc=%0d, required 1", pc);
        end
        fetch(); exec(); fetch(); exec();
        n_tests++;
        if (acc !== 8'd12) begin
            n_fail++; $display("FAIL gate_mem: acc=%0d, required 12", acc);
        end
        cycle(2'b00, 1'b1, 7, 8'h3A, 1'b1);
        n_tests++;
        if (pc !== 4'd0) begin
            n_fail++; $display("FAIL idle_pc_clr: pc=%0d, required 0", pc);
        end
        fetch(); exec(); fetch(); exec(); fetch(); exec();
        n_tests++;
        if (acc !== 8'd26) begin
            n_fail++; $display("FAIL idle_write: acc=%0d, required 26", acc);
        end
    endtask

    task automatic test_reset_mid();
        int prog [4] = '{8'h25, 8'h43, 8'hC0, 8'hE0};
        for (int i = 0; i < 4; i++) write_mem(i, prog[i]);
        clear_pc();
        for (int i = 0; i < 3; i++) begin fetch(); exec(); end
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== 8'd8) begin
            n_fail++; $display("FAIL pre_reset_out: out_valid=%0b out_data=%0d, required 1/8", out_valid, out_data);
        end
        reset = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || out_data !== 8'd0 || acc !== 8'd0 || pc !== 4'd0) begin
            n_fail++; $display("FAIL mid_reset: out_valid=%0b out_data=%0d acc=%0d pc=%0d, required all 0",
                               out_valid, out_data, acc, pc);
        end
        #3 reset = 1'b1;
        clear_pc();
        for (int i = 0; i < 3; i++) begin fetch(); exec(); end
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== 8'd8 || acc !== 8'd8) begin
            n_fail++; $display("FAIL rerun_out: out_valid=%0b out_data=%0d acc=%0d, required 1/8/8",
                               out_valid, out_data, acc);
        end
    endtask

    task automatic test_random();
        logic [1:0] c;
        int r;
        for (int i = 0; i < DEPTH; i++) write_mem(i, int'($urandom_range(0, 255)));
        clear_pc();
        for (int n = 0; n < 300; n++) begin
            r = int'($urandom_range(0, 9));
            c = (r < 2) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            cs = c; #1;
            n_tests++;
            if (halt !== (c == 2'b10 && m_ir / 32 == 7)) begin
                n_fail++; $display("FAIL rand_halt%0d: halt=%0b, required %0b", n, halt, (c == 2'b10 && m_ir / 32 == 7));
            end
            cycle(c, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0));
            n_tests++;
            if (pc !== 4'(m_pc) || acc !== 8'(m_acc) || carry !== 1'(m_carry) ||
                out_data !== 8'(m_od) || out_valid !== 1'(m_ov)) begin
                n_fail++;
                $display("FAIL rand_state%0d: pc=%0d acc=%0d carry=%0b out=%0d ov=%0b, required %0d/%0d/%0d/%0d/%0d",
                         n, pc, acc, carry, out_data, out_valid, m_pc, m_acc, m_carry, m_od, m_ov);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_run();
        test_carry();
        test_jumps();
        test_write_gating();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
